// File: rtl/multicycle_alu_pkg.sv
// Shared ALU op codes and FSM state encoding.
// Used by the ALU control decoder and the execute stage.
package multicycle_alu_pkg;

  localparam int OP_WIDTH = 4;

  localparam logic [OP_WIDTH-1:0] OP_AND  = 4'b0000;
  localparam logic [OP_WIDTH-1:0] OP_OR   = 4'b0001;
  localparam logic [OP_WIDTH-1:0] OP_NOR  = 4'b0010;
  localparam logic [OP_WIDTH-1:0] OP_ADD  = 4'b0011;
  localparam logic [OP_WIDTH-1:0] OP_SUB  = 4'b0100;
  localparam logic [OP_WIDTH-1:0] OP_SLL  = 4'b1000;
  localparam logic [OP_WIDTH-1:0] OP_SRL  = 4'b1001;
  localparam logic [OP_WIDTH-1:0] OP_LDST = 4'b1010;
  localparam logic [OP_WIDTH-1:0] OP_JR   = 4'b1011;
  localparam logic [OP_WIDTH-1:0] OP_BEQ  = 4'b1100;
  localparam logic [OP_WIDTH-1:0] OP_LUI  = 4'b1110;
  localparam logic [OP_WIDTH-1:0] OP_BAD  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic is_shift(
    input logic [OP_WIDTH-1:0] op
  );
    return (op == OP_SLL) || (op == OP_SRL);
  endfunction

endpackage

// File: rtl/multicycle_alu_if.sv
// Start/ready/done handshake and operand bus
// between the datapath controller and the ALU.
interface multicycle_alu_if
  import multicycle_alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
);

  logic                   start;
  logic [OP_WIDTH-1:0]    ALUOperation;
  logic [DATA_WIDTH-1:0]  A;
  logic [DATA_WIDTH-1:0]  B;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   ready;
  logic                   busy;
  logic                   done;
  logic [DATA_WIDTH-1:0]  ALUResult;
  logic                   Zero;
  logic                   Error;

  modport master (
    output start, ALUOperation, A, B, shamt,
    input  ready, busy, done,
    input  ALUResult, Zero, Error
  );

  modport slave (
    input  start, ALUOperation, A, B, shamt,
    output ready, busy, done,
    output ALUResult, Zero, Error
  );

endinterface

// File: rtl/multicycle_alu_comb_unit.sv
// Combinational result for every non-shift op,
// plus the unsupported-op flag.
module alu_comb_unit
  import multicycle_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [OP_WIDTH-1:0]   op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] res_o,
  output logic                  err_o
);

  // Decode op; shift codes return B so a
  // zero-length shift completes right here.
  always_comb begin
    res_o = '0;
    err_o = 1'b0;
    unique case (op_i)
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_NOR:  res_o = ~(a_i | b_i);
      OP_ADD:  res_o = a_i + b_i;
      OP_SUB:  res_o = a_i - b_i;
      OP_SLL:  res_o = b_i;
      OP_SRL:  res_o = b_i;
      OP_LDST: res_o = a_i + b_i;
      OP_JR:   res_o = a_i;
      OP_BEQ:  res_o = a_i - b_i;
      OP_LUI:
        res_o = {b_i[15:0],
                 {(DATA_WIDTH-16){1'b0}}};
      default: begin
        res_o = '0;
        err_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: single-cycle ops in one
// clock, shifts iterate one bit per clock.
module multicycle_alu
  import multicycle_alu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input logic clk,
  input logic reset,
  multicycle_alu_if.slave bus
);

  localparam int DW = DATA_WIDTH;
  localparam int SW = SHAMT_WIDTH;

  state_e          state_q, state_d;
  logic [DW-1:0]   res_q, res_d;
  logic            zero_q, zero_d;
  logic            err_q, err_d;
  logic [DW-1:0]   sh_q, sh_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic            right_q, right_d;

  logic [DW-1:0]   comb_res;
  logic            comb_err;
  logic [DW-1:0]   sh_step;

  alu_comb_unit #(
    .DATA_WIDTH (DW)
  ) u_comb (
    .op_i  (bus.ALUOperation),
    .a_i   (bus.A),
    .b_i   (bus.B),
    .res_o (comb_res),
    .err_o (comb_err)
  );

  assign sh_step = right_q ? (sh_q >> 1)
                           : (sh_q << 1);

  // Next state, result write-back and shifter
  // load/step; everything holds by default.
  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    zero_d  = zero_q;
    err_d   = err_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    right_d = right_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus.start) begin
          if (is_shift(bus.ALUOperation) &&
              (bus.shamt != '0)) begin
            sh_d    = bus.B;
            cnt_d   = bus.shamt;
            right_d = (bus.ALUOperation == OP_SRL);
            state_d = ST_SHIFT;
          end else begin
            res_d   = comb_res;
            zero_d  = (comb_res == '0);
            err_d   = comb_err;
            state_d = ST_DONE;
          end
        end
      end
      ST_SHIFT: begin
        sh_d  = sh_step;
        cnt_d = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          res_d   = sh_step;
          zero_d  = (sh_step == '0);
          err_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts
  // any shift in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      sh_q    <= '0;
      cnt_q   <= '0;
      right_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      right_q <= right_d;
    end
  end

  assign bus.ready     = (state_q != ST_SHIFT);
  assign bus.busy      = (state_q == ST_SHIFT);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.ALUResult = res_q;
  assign bus.Zero      = zero_q;
  assign bus.Error     = err_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Randomized bench for multicycle_alu with an
// op-level reference model and per-cycle compare.
module tb_multicycle_alu;
  import multicycle_alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  multicycle_alu_if #(
    .DATA_WIDTH  (32),
    .SHAMT_WIDTH (5)
  ) bus ();

  multicycle_alu #(
    .DATA_WIDTH  (32),
    .SHAMT_WIDTH (5)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(
    input logic [3:0] op,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0] sh);
    logic [15:0] lo;
    lo = b[15:0];
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return ~(a | b);
      4'b0011: return a + b;
      4'b0100: return a - b;
      4'b1000: return b << sh;
      4'b1001: return b >> sh;
      4'b1010: return a + b;
      4'b1011: return a;
      4'b1100: return a - b;
      4'b1110: return {lo, 16'h0000};
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic ref_err(
    input logic [3:0] op);
    case (op)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0100, 4'b1000, 4'b1001, 4'b1010,
      4'b1011, 4'b1100, 4'b1110: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Reference model: an op occupies the unit for
  // shamt clocks when it is a nonzero shift,
  // otherwise completes at the accept edge.
  logic [31:0] m_res, m_pend;
  logic        m_zero, m_err, m_done, m_busy;
  int          m_wait;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_res  <= 32'h0;
      m_pend <= 32'h0;
      m_zero <= 1'b0;
      m_err  <= 1'b0;
      m_done <= 1'b0;
      m_busy <= 1'b0;
      m_wait <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_wait <= m_wait - 1;
        if (m_wait == 1) begin
          m_busy <= 1'b0;
          m_res  <= m_pend;
          m_zero <= (m_pend == 32'h0);
          m_err  <= 1'b0;
          m_done <= 1'b1;
        end
      end else if (bus.start) begin
        if ((bus.ALUOperation == 4'b1000 ||
             bus.ALUOperation == 4'b1001) &&
            bus.shamt != 5'd0) begin
          m_busy <= 1'b1;
          m_wait <= int'(bus.shamt);
          m_pend <= ref_res(bus.ALUOperation,
                            bus.A, bus.B,
                            bus.shamt);
        end else begin
          m_res  <= ref_res(bus.ALUOperation,
                            bus.A, bus.B,
                            bus.shamt);
          m_zero <= (ref_res(bus.ALUOperation,
                             bus.A, bus.B,
                             bus.shamt) == 32'h0);
          m_err  <= ref_err(bus.ALUOperation);
          m_done <= 1'b1;
        end
      end
    end
  end

  // Compare every output against the model on
  // every falling edge.
  always @(negedge clk) begin
    chk("ready", 32'(bus.ready), 32'(!m_busy));
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("result", bus.ALUResult, m_res);
    chk("zero", 32'(bus.Zero), 32'(m_zero));
    chk("error", 32'(bus.Error), 32'(m_err));
  end

  task automatic scramble();
    bus.A = $urandom;
    bus.B = $urandom;
    bus.shamt = 5'($urandom);
    bus.ALUOperation = 4'($urandom);
  endtask

  // Issue one op at a falling edge and wait
  // (bounded) until its done pulse is visible.
  task automatic issue(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [4:0] sh,
                       input bit scr,
                       output int nb);
    bit ok;
    ok = 1'b0;
    nb = 0;
    for (int i = 0; i < 100 && !bus.ready; i++)
      @(negedge clk);
    bus.start = 1'b1;
    bus.ALUOperation = op;
    bus.A = a;
    bus.B = b;
    bus.shamt = sh;
    @(negedge clk);
    bus.start = 1'b0;
    if (scr) scramble();
    for (int i = 0; i < 100; i++) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy) nb++;
      if (scr) begin
        scramble();
        bus.start = 1'($urandom);
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("done_seen", 32'(ok), 32'd1);
  endtask

  task automatic run_lit(input string nm,
                         input logic [3:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [4:0] sh,
                         input bit scr,
                         input logic [31:0] er,
                         input logic ez,
                         input logic ee,
                         input int eb);
    int nb;
    issue(op, a, b, sh, scr, nb);
    chk({nm, "_res"}, bus.ALUResult, er);
    chk({nm, "_zero"}, 32'(bus.Zero), 32'(ez));
    chk({nm, "_err"}, 32'(bus.Error), 32'(ee));
    chk({nm, "_busycyc"}, 32'(nb), 32'(eb));
    chk({nm, "_model"}, m_res, er);
  endtask

  initial begin
    int nb;
    logic [3:0] op;
    logic [31:0] a, b;
    logic [4:0] sh;
    bus.start = 1'b0;
    bus.ALUOperation = 4'h0;
    bus.A = 32'h0;
    bus.B = 32'h0;
    bus.shamt = 5'd0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_res", bus.ALUResult, 32'h0);
    chk("rst_zero", 32'(bus.Zero), 32'd0);
    chk("rst_err", 32'(bus.Error), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_ready", 32'(bus.ready), 32'd1);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_res", bus.ALUResult, 32'h0);
    chk("idle_done", 32'(bus.done), 32'd0);
    chk("idle_ready", 32'(bus.ready), 32'd1);

    run_lit("add_wrap", OP_ADD, 32'hFFFFFFFF,
            32'h1, 5'd0, 0, 32'h0, 1, 0, 0);
    run_lit("sub", OP_SUB, 32'd5, 32'd3, 5'd0,
            0, 32'd2, 0, 0, 0);
    run_lit("sll31", OP_SLL, 32'h0, 32'h1,
            5'd31, 0, 32'h80000000, 0, 0, 31);
    run_lit("srl4", OP_SRL, 32'h0, 32'h80000000,
            5'd4, 0, 32'h08000000, 0, 0, 4);
    run_lit("sll0", OP_SLL, 32'h0, 32'h1234,
            5'd0, 0, 32'h1234, 0, 0, 0);
    run_lit("lui", OP_LUI, 32'h0, 32'h0000ABCD,
            5'd0, 0, 32'hABCD0000, 0, 0, 0);
    run_lit("jr", OP_JR, 32'h00400020, 32'h5,
            5'd0, 0, 32'h00400020, 0, 0, 0);
    run_lit("beq", OP_BEQ, 32'd7, 32'd7, 5'd0,
            0, 32'h0, 1, 0, 0);
    run_lit("bad", OP_BAD, 32'h3, 32'h4, 5'd0,
            0, 32'h0, 1, 1, 0);
    run_lit("and", OP_AND, 32'hF0F0, 32'hFF00,
            5'd0, 0, 32'hF000, 0, 0, 0);
    run_lit("srl_scr", OP_SRL, 32'h0,
            32'hF0000000, 5'd8, 1,
            32'h00F00000, 0, 0, 8);

    bus.start = 1'b1;
    bus.ALUOperation = OP_SLL;
    bus.B = 32'h3;
    bus.shamt = 5'd20;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("abort_res", bus.ALUResult, 32'h0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_ready", 32'(bus.ready), 32'd1);
    #2 rst_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("abort_nodone_res", bus.ALUResult,
        32'h0);

    for (int k = 0; k < 300; k++) begin
      op = 4'($urandom);
      if ($urandom % 3 == 0)
        op = ($urandom % 2) ? OP_SLL : OP_SRL;
      a = $urandom;
      b = $urandom;
      if ($urandom % 8 == 0) b = a;
      sh = ($urandom % 4 == 0) ? 5'd0
                               : 5'($urandom);
      issue(op, a, b, sh,
            ($urandom % 4 == 0), nb);
      if ($urandom % 3 == 0) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
